mac_tile_sched: RTL and testbench
=================================

MAC_TILE_SCHED -- requirements
Module: mac_tile_sched

Interface
REQ-001 The block SHALL have parameter MAX_MACS, default 32, meaning lanes per MAC issue (1..64).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning data/weight element width.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 12, meaning job length counter width in elements.
REQ-004 The block SHALL have parameter ACC_WIDTH, default 24, meaning accumulator width, constrained to ACC_WIDTH >= 2*DATA_WIDTH.
REQ-005 clk  input  1  clock; all logic on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 job_valid / job_ready  input / output  1 / 1  job handshake.
REQ-008 job_len  input  LEN_WIDTH  number of elements in the dot product.
REQ-009 in_valid / in_ready  input / output  1 / 1  operand chunk handshake.
REQ-010 in_data / in_weight  input  MAX_MACS*DATA_WIDTH each  operand chunk, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 mac_num_macs  output  7  active lane count driven to the MAC unit.
REQ-012 mac_valid_in  output  1  single-cycle issue strobe to the MAC unit.
REQ-013 mac_data / mac_weight  output  MAX_MACS*DATA_WIDTH each  registered operands to the MAC unit.
REQ-014 mac_out_i / mac_valid_out_i  input  2*DATA_WIDTH / 1  partial sum and its strobe from the MAC unit.
REQ-015 res_valid / res_ready / res_data  output / input / output  1 / 1 / ACC_WIDTH  result handshake and value.
REQ-016 busy / err  output  1 / 1  busy = not IDLE; err = sticky spurious-strobe flag.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, ISSUE, WAIT, DONE.
REQ-018 job_ready SHALL be 1 exactly in IDLE; on job_valid && job_ready the block SHALL clear acc, load remaining = job_len, and go to FETCH, or to DONE with acc = 0 and no input consumed when job_len == 0.
REQ-019 in_ready SHALL be 1 exactly in FETCH; on in_valid the block SHALL register operands, set chunk = min(remaining, MAX_MACS), and go to ISSUE.
REQ-020 Lanes with index >= chunk SHALL be driven as zero on mac_data and mac_weight.
REQ-021 In ISSUE, mac_valid_in SHALL be 1 for exactly one cycle and the state SHALL go to WAIT.
REQ-022 mac_num_macs, mac_data and mac_weight SHALL remain stable from ISSUE through the cycle of mac_valid_out_i in WAIT.
REQ-023 In WAIT, on mac_valid_out_i the block SHALL add mac_out_i zero-extended to acc and subtract chunk from remaining.
REQ-024 After that WAIT update the block SHALL go to DONE if the new remaining == 0, else to FETCH; there is no timeout.
REQ-025 In DONE, res_valid SHALL be 1 with res_data = acc held stable until res_ready, then the state SHALL go to IDLE.
REQ-026 The block SHALL accept the next job no earlier than one cycle after the result handshake.
REQ-027 mac_valid_out_i outside WAIT SHALL be ignored for acc and SHALL set err, which stays 1 until reset.
REQ-028 job_valid outside IDLE and in_valid outside FETCH SHALL have no effect.
REQ-029 Accumulation SHALL be unsigned and wrap modulo 2^ACC_WIDTH unless REQ-033 applies.

Reset
REQ-030 While rst is high the block SHALL hold state = IDLE, acc = 0, remaining = 0, and outputs mac_valid_in = 0, mac_num_macs = 0, mac_data = 0, mac_weight = 0, res_valid = 0, res_data = 0, in_ready = 0, busy = 0, err = 0, job_ready = 1.
REQ-031 Reset asserted mid-job SHALL abandon the job with no res_valid, and a late mac_valid_out_i after reset SHALL set err.

Configuration
REQ-032 The macro MAC_TILE_SCHED_SAT_EN SHALL select saturating accumulation.
REQ-033 With MAC_TILE_SCHED_SAT_EN defined, an add that overflows SHALL clamp acc to 2^ACC_WIDTH-1, and acc SHALL hold that value for the rest of the job.
REQ-034 Without MAC_TILE_SCHED_SAT_EN, accumulation SHALL wrap per REQ-029 and no saturation logic SHALL be present.

Verification
REQ-035 job_len=32, all data=1 and weight=1 -> one issue with mac_num_macs=32, then res_data=32 and err=0.
REQ-036 job_len=40, data=2, weight=3 -> issues with mac_num_macs=32 then 8, lanes 8..31 zero on the second issue, res_data=240.
REQ-037 job_len=0 -> in_ready never asserted, mac_valid_in never asserted, res_valid=1 with res_data=0.
REQ-038 res_ready held low for 10 cycles -> res_valid and res_data stable and job_ready=0 throughout; job accepted only after the handshake.
REQ-039 ACC_WIDTH=16, job_len=2 as two 1-lane jobs is not used; instead MAX_MACS=1, job_len=2, data=weight=255 -> res_data=64514 without the macro, 65535 with MAC_TILE_SCHED_SAT_EN.
REQ-040 rst pulsed during WAIT, then a stray mac_valid_out_i -> state IDLE, res_valid=0, err=1.

Source files
------------

// File: rtl/mac_tile_sched.sv
// mac_tile_sched -- splits a dot-product job into chunks of up to MAX_MACS
// lanes, issues each chunk to an external MAC unit and accumulates the
// returned partial sums into a single result.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   job_valid/job_ready/job_len   job handshake and element count
//   in_valid/in_ready             operand chunk handshake
//   in_data/in_weight             operand chunk, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   mac_num_macs                  active lane count for the current issue
//   mac_valid_in                  single-cycle issue strobe
//   mac_data/mac_weight           registered operands, inactive lanes zeroed
//   mac_out_i/mac_valid_out_i     partial sum and strobe from the MAC unit
//   res_valid/res_ready/res_data  result handshake and accumulated value
//   busy                          high whenever not idle
//   err                           sticky: MAC strobe seen outside WAIT
//
// Build option: define MAC_TILE_SCHED_SAT_EN for saturating accumulation;
// otherwise the accumulator wraps modulo 2^ACC_WIDTH.
// ACC_WIDTH must be >= 2*DATA_WIDTH.

module mac_tile_sched #(
  parameter int unsigned MAX_MACS   = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 12,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           job_valid,
  output logic                           job_ready,
  input  logic [LEN_WIDTH-1:0]           job_len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [MAX_MACS*DATA_WIDTH-1:0] in_data,
  input  logic [MAX_MACS*DATA_WIDTH-1:0] in_weight,
  output logic [6:0]                     mac_num_macs,
  output logic                           mac_valid_in,
  output logic [MAX_MACS*DATA_WIDTH-1:0] mac_data,
  output logic [MAX_MACS*DATA_WIDTH-1:0] mac_weight,
  input  logic [2*DATA_WIDTH-1:0]        mac_out_i,
  input  logic                           mac_valid_out_i,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [ACC_WIDTH-1:0]           res_data,
  output logic                           busy,
  output logic                           err
);

  localparam int unsigned VW = MAX_MACS * DATA_WIDTH;
  // Compare width wide enough for both the remaining count and MAX_MACS.
  localparam int unsigned CW = (LEN_WIDTH > 7) ? LEN_WIDTH : 7;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d, acc_add;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [6:0]             chunk_q, chunk_d, chunk_nxt;
  logic [VW-1:0]          data_q, data_d;
  logic [VW-1:0]          weight_q, weight_d;
  logic                   err_q, err_d;
  logic [CW-1:0]          rem_ext;

`ifdef MAC_TILE_SCHED_SAT_EN
  localparam int unsigned AW1 = ACC_WIDTH + 1;
  logic [ACC_WIDTH:0]     sum_wide;

  // Once clamped at all-ones, any further non-zero add overflows again and
  // a zero add leaves it unchanged, so the clamp holds for the rest of the
  // job without a separate flag.
  always_comb begin
    sum_wide = {1'b0, acc_q} + AW1'(mac_out_i);
    acc_add  = sum_wide[ACC_WIDTH] ? '1 : sum_wide[ACC_WIDTH-1:0];
  end
`else
  always_comb begin
    acc_add = acc_q + ACC_WIDTH'(mac_out_i);
  end
`endif

  always_comb begin
    rem_ext = CW'(rem_q);
    if (rem_ext > CW'(MAX_MACS)) begin
      chunk_nxt = 7'(MAX_MACS);
    end else begin
      chunk_nxt = 7'(rem_ext);
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    chunk_d  = chunk_q;
    data_d   = data_q;
    weight_d = weight_q;
    err_d    = err_q;

    if (mac_valid_out_i && (state_q != WAIT)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (job_valid) begin
          acc_d   = '0;
          rem_d   = job_len;
          state_d = (job_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (in_valid) begin
          chunk_d = chunk_nxt;
          for (int unsigned i = 0; i < MAX_MACS; i++) begin
            if (i < 32'(chunk_nxt)) begin
              data_d[i*DATA_WIDTH +: DATA_WIDTH]   = in_data[i*DATA_WIDTH +: DATA_WIDTH];
              weight_d[i*DATA_WIDTH +: DATA_WIDTH] = in_weight[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
              data_d[i*DATA_WIDTH +: DATA_WIDTH]   = '0;
              weight_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mac_valid_out_i) begin
          acc_d   = acc_add;
          rem_d   = rem_q - LEN_WIDTH'(chunk_q);
          state_d = (rem_d == '0) ? DONE : FETCH;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      chunk_q  <= '0;
      data_q   <= '0;
      weight_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      chunk_q  <= chunk_d;
      data_q   <= data_d;
      weight_q <= weight_d;
      err_q    <= err_d;
    end
  end

  assign job_ready    = (state_q == IDLE);
  assign in_ready     = (state_q == FETCH);
  assign mac_valid_in = (state_q == ISSUE);
  assign res_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign mac_num_macs = chunk_q;
  assign mac_data     = data_q;
  assign mac_weight   = weight_q;
  assign res_data     = acc_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mac_tile_sched.sv
module tb_mac_tile_sched;

  logic clk;
  logic rst;

  // DUT A: default parameters
  logic         a_job_valid, a_job_ready;
  logic [11:0]  a_job_len;
  logic         a_in_valid, a_in_ready;
  logic [255:0] a_in_data, a_in_weight;
  logic [6:0]   a_mac_num_macs;
  logic         a_mac_valid_in;
  logic [255:0] a_mac_data, a_mac_weight;
  logic [15:0]  a_mac_out;
  logic         a_mac_valid_out;
  logic         a_res_valid, a_res_ready;
  logic [23:0]  a_res_data;
  logic         a_busy, a_err;

  // DUT B: one lane, 16-bit accumulator
  logic         b_job_valid, b_job_ready;
  logic [11:0]  b_job_len;
  logic         b_in_valid, b_in_ready;
  logic [7:0]   b_in_data, b_in_weight;
  logic [6:0]   b_mac_num_macs;
  logic         b_mac_valid_in;
  logic [7:0]   b_mac_data, b_mac_weight;
  logic [15:0]  b_mac_out;
  logic         b_mac_valid_out;
  logic         b_res_valid, b_res_ready;
  logic [15:0]  b_res_data;
  logic         b_busy, b_err;

  int n_chk  = 0;
  int n_fail = 0;

  mac_tile_sched dut_a (
    .clk(clk), .rst(rst),
    .job_valid(a_job_valid), .job_ready(a_job_ready), .job_len(a_job_len),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_weight(a_in_weight),
    .mac_num_macs(a_mac_num_macs), .mac_valid_in(a_mac_valid_in),
    .mac_data(a_mac_data), .mac_weight(a_mac_weight),
    .mac_out_i(a_mac_out), .mac_valid_out_i(a_mac_valid_out),
    .res_valid(a_res_valid), .res_ready(a_res_ready), .res_data(a_res_data),
    .busy(a_busy), .err(a_err)
  );

  mac_tile_sched #(
    .MAX_MACS(1), .DATA_WIDTH(8), .LEN_WIDTH(12), .ACC_WIDTH(16)
  ) dut_b (
    .clk(clk), .rst(rst),
    .job_valid(b_job_valid), .job_ready(b_job_ready), .job_len(b_job_len),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_weight(b_in_weight),
    .mac_num_macs(b_mac_num_macs), .mac_valid_in(b_mac_valid_in),
    .mac_data(b_mac_data), .mac_weight(b_mac_weight),
    .mac_out_i(b_mac_out), .mac_valid_out_i(b_mac_valid_out),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_data(b_res_data),
    .busy(b_busy), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference MAC unit: sum of lane products truncated to 16 bits.
  function automatic logic [15:0] mac_model(input logic [255:0] d, input logic [255:0] w);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 32; i++) s += 32'(d[i*8 +: 8]) * 32'(w[i*8 +: 8]);
    return 16'(s);
  endfunction

  function automatic logic [255:0] lanes(input int n, input logic [7:0] v);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  task automatic start_job(input logic [11:0] len);
    a_job_valid = 1'b1;
    a_job_len   = len;
    @(negedge clk);
    a_job_valid = 1'b0;
  endtask

  task automatic feed(input logic [255:0] d, input logic [255:0] w);
    for (int k = 0; k < 20 && !a_in_ready; k++) @(negedge clk);
    chk("in_ready", a_in_ready, 1);
    a_in_valid  = 1'b1;
    a_in_data   = d;
    a_in_weight = w;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic respond(input logic [6:0] nm, input logic [255:0] ed, input logic [255:0] ew);
    logic [15:0] p;
    for (int k = 0; k < 20 && !a_mac_valid_in; k++) @(negedge clk);
    chk("mac_valid_in", a_mac_valid_in, 1);
    chk("mac_num_macs", a_mac_num_macs, nm);
    chk("mac_data", a_mac_data, ed);
    chk("mac_weight", a_mac_weight, ew);
    p = mac_model(a_mac_data, a_mac_weight);
    @(negedge clk);
    chk("mac_valid_in_pulse", a_mac_valid_in, 0);
    repeat (2) @(negedge clk);
    chk("num_macs_stable", a_mac_num_macs, nm);
    chk("mac_data_stable", a_mac_data, ed);
    a_mac_out       = p;
    a_mac_valid_out = 1'b1;
    @(negedge clk);
    a_mac_valid_out = 1'b0;
    a_mac_out       = '0;
  endtask

  task automatic result(input logic [23:0] exp);
    for (int k = 0; k < 20 && !a_res_valid; k++) @(negedge clk);
    chk("res_valid", a_res_valid, 1);
    chk("res_data", a_res_data, exp);
    a_res_ready = 1'b1;
    @(negedge clk);
    a_res_ready = 1'b0;
    chk("idle_busy", a_busy, 0);
    chk("idle_job_ready", a_job_ready, 1);
  endtask

  initial begin
    logic         ok;
    logic         seen;
    logic [255:0] d, w;

    rst = 1'b1;
    a_job_valid = 0; a_job_len = 0; a_in_valid = 0; a_in_data = '0; a_in_weight = '0;
    a_mac_out = 0; a_res_ready = 0;
    b_job_valid = 0; b_job_len = 0; b_in_valid = 0; b_in_data = 0; b_in_weight = 0;
    b_mac_out = 0; b_mac_valid_out = 0; b_res_ready = 0;
    // Stray strobe while in reset must not set err.
    a_mac_valid_out = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_job_ready", a_job_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_mac_valid_in", a_mac_valid_in, 0);
    chk("rst_res_valid", a_res_valid, 0);
    chk("rst_res_data", a_res_data, 0);
    chk("rst_err", a_err, 0);
    chk("rst_num_macs", a_mac_num_macs, 0);
    chk("rst_mac_data", a_mac_data, 0);
    chk("rst_mac_weight", a_mac_weight, 0);
    a_mac_valid_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 32 elements of 1*1 in one issue
    start_job(12'd32);
    feed(lanes(32, 8'd1), lanes(32, 8'd1));
    respond(7'd32, lanes(32, 8'd1), lanes(32, 8'd1));
    result(24'd32);
    chk("err_after_job1", a_err, 0);

    // 40 elements of 2*3: 32-lane issue then 8-lane issue
    start_job(12'd40);
    feed(lanes(32, 8'd2), lanes(32, 8'd3));
    respond(7'd32, lanes(32, 8'd2), lanes(32, 8'd3));
    feed(lanes(32, 8'd2), lanes(32, 8'd3));
    respond(7'd8, lanes(8, 8'd2), lanes(8, 8'd3));
    result(24'd240);

    // Zero-length job: no fetch, no issue; in_valid in DONE ignored
    start_job(12'd0);
    seen = 1'b0;
    a_in_valid = 1'b1;
    a_in_data  = lanes(32, 8'd7);
    a_in_weight = lanes(32, 8'd7);
    for (int k = 0; k < 3; k++) begin
      seen = seen | a_in_ready | a_mac_valid_in;
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    chk("len0_no_fetch_issue", seen, 0);
    result(24'd0);

    // One element, other lanes non-zero (masked), result held under back-pressure
    d = lanes(32, 8'd9); d[7:0] = 8'd5;
    w = lanes(32, 8'd9); w[7:0] = 8'd7;
    start_job(12'd1);
    feed(d, w);
    respond(7'd1, lanes(1, 8'd5), lanes(1, 8'd7));
    for (int k = 0; k < 20 && !a_res_valid; k++) @(negedge clk);
    a_job_valid = 1'b1;
    a_job_len   = 12'd0;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ok = ok & (a_res_valid === 1'b1) & (a_res_data === 24'd35) & (a_job_ready === 1'b0);
      @(negedge clk);
    end
    chk("hold_under_backpressure", ok, 1);
    a_res_ready = 1'b1;
    @(negedge clk);
    a_res_ready = 1'b0;
    chk("post_hs_job_ready", a_job_ready, 1);
    chk("post_hs_busy", a_busy, 0);
    chk("post_hs_res_valid", a_res_valid, 0);
    @(negedge clk);
    a_job_valid = 1'b0;
    chk("next_job_accepted", a_busy, 1);
    result(24'd0);

    // Reset during WAIT, then a late strobe
    start_job(12'd4);
    feed(lanes(32, 8'd1), lanes(32, 8'd1));
    for (int k = 0; k < 20 && !a_mac_valid_in; k++) @(negedge clk);
    @(negedge clk);
    chk("wait_busy", a_busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_job_ready", a_job_ready, 1);
    chk("midrst_num_macs", a_mac_num_macs, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a_mac_out       = 16'd4;
    a_mac_valid_out = 1'b1;
    @(negedge clk);
    a_mac_valid_out = 1'b0;
    a_mac_out       = '0;
    chk("stray_err", a_err, 1);
    chk("stray_busy", a_busy, 0);
    chk("stray_res_valid", a_res_valid, 0);
    chk("stray_res_data", a_res_data, 0);
    repeat (2) @(negedge clk);
    chk("err_sticky", a_err, 1);

    // One lane, 16-bit accumulator: 255*255 twice
    b_job_len   = 12'd2;
    b_job_valid = 1'b1;
    @(negedge clk);
    b_job_valid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 20 && !b_in_ready; k++) @(negedge clk);
      chk("b_in_ready", b_in_ready, 1);
      b_in_valid  = 1'b1;
      b_in_data   = 8'hFF;
      b_in_weight = 8'hFF;
      @(negedge clk);
      b_in_valid = 1'b0;
      chk("b_mac_valid_in", b_mac_valid_in, 1);
      chk("b_num_macs", b_mac_num_macs, 1);
      chk("b_mac_data", b_mac_data, 8'hFF);
      chk("b_mac_weight", b_mac_weight, 8'hFF);
      @(negedge clk);
      b_mac_out       = 16'd65025;
      b_mac_valid_out = 1'b1;
      @(negedge clk);
      b_mac_valid_out = 1'b0;
      b_mac_out       = '0;
    end
    for (int k = 0; k < 20 && !b_res_valid; k++) @(negedge clk);
    chk("b_res_valid", b_res_valid, 1);
`ifdef MAC_TILE_SCHED_SAT_EN
    chk("b_res_data", b_res_data, 16'd65535);
`else
    chk("b_res_data", b_res_data, 16'd64514);
`endif
    b_res_ready = 1'b1;
    @(negedge clk);
    b_res_ready = 1'b0;
    chk("b_idle", b_busy, 0);
    chk("b_job_ready", b_job_ready, 1);
    chk("b_err", b_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
